// File: rtl/lovers_bec_sequencer.sv
// lovers_bec_sequencer: host-facing sequencer for the binary-Edwards-curve
// scalar-multiplication core. It fetches NUM_OPER operands from the host and
// loads them into the core one slot at a time. It then runs the core while
// streaming the scalar MSB-first, and captures the result when the core
// reports done. A watchdog bounds the run phase; abort returns to IDLE from
// any active state.
module lovers_bec_sequencer #(
    parameter int DW       = 163,
    parameter int NUM_OPER = 6,
    parameter int KEY_BITS = 163,
    parameter int TIMEOUT  = 1 << 20
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start,
    input  logic                abort,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                op_req,
    output logic [2:0]          op_idx,
    input  logic                op_valid,
    input  logic [DW-1:0]       op_data,
    output logic                enable,
    output logic                load_data,
    output logic [2:0]          load_status,
    output logic [DW-1:0]       data_out,
    input  logic                trigLoad,
    output logic                ki,
    input  logic                next_key,
    input  logic [3:0]          becStatus,
    input  logic [DW-1:0]       data_in,
    input  logic                done,
    output logic                busy,
    output logic [DW-1:0]       result,
    output logic                result_valid,
    output logic                timeout_err,
    output logic [3:0]          status
);

    // Bit index must address KEY_BITS positions; the watchdog counter must
    // hold TIMEOUT-1, the value at which it fires on the following edge.
    localparam int BW  = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BW-1:0]  BIT_TOP   = BW'(KEY_BITS - 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [2:0]     SLOT_LAST = 3'(NUM_OPER - 1);
    localparam bit             WD_ON     = (TIMEOUT > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_STROBE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t              state;
    logic [KEY_BITS-1:0] key_reg;
    logic [BW-1:0]       bit_idx;
    logic                key_exh;   // bit 0 already consumed; ki forced low
    logic [2:0]          slot;
    logic [WDW-1:0]      wdog;

    // Key bit presented to the core: only meaningful while running, and
    // pinned low once the whole scalar has been consumed.
    assign ki = (state == S_RUN) && !key_exh && key_reg[bit_idx];

    // Main sequencer: operand fetch/load handshake, run control, watchdog
    // and result capture. Abort outranks every other transition.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= S_IDLE;
            key_reg      <= '0;
            bit_idx      <= '0;
            key_exh      <= 1'b0;
            slot         <= '0;
            wdog         <= '0;
            op_req       <= 1'b0;
            op_idx       <= '0;
            enable       <= 1'b0;
            load_data    <= 1'b0;
            load_status  <= '0;
            data_out     <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else if (abort && (state != S_IDLE)) begin
            // timeout_err is left alone so a prior watchdog event stays visible
            state        <= S_IDLE;
            op_req       <= 1'b0;
            enable       <= 1'b0;
            load_data    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key_reg      <= key_in;
                        bit_idx      <= BIT_TOP;
                        key_exh      <= 1'b0;
                        slot         <= '0;
                        op_idx       <= '0;
                        op_req       <= 1'b1;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        timeout_err  <= 1'b0;
                        state        <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    // data_out/load_status are captured here and held through
                    // STROBE so the core sees a stable bus for the whole load.
                    if (op_valid) begin
                        data_out    <= op_data;
                        load_status <= slot;
                        op_req      <= 1'b0;
                        state       <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (trigLoad) begin
                        load_data <= 1'b1;
                        state     <= S_STROBE;
                    end
                end

                S_STROBE: begin
                    load_data <= 1'b0;
                    if (slot == SLOT_LAST) begin
                        enable <= 1'b1;
                        wdog   <= '0;
                        state  <= S_RUN;
                    end else begin
                        slot   <= slot + 3'd1;
                        op_idx <= slot + 3'd1;
                        op_req <= 1'b1;
                        state  <= S_FETCH;
                    end
                end

                S_RUN: begin
                    if (done) begin
                        // Capture wins over a coincident next_key; flags are
                        // set on this edge so they read valid during FINISH.
                        result       <= data_in;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        enable       <= 1'b0;
                        state        <= S_FINISH;
                    end else if (WD_ON && (wdog == WD_LAST)) begin
                        timeout_err <= 1'b1;
                        enable      <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                        if (next_key) begin
                            if (bit_idx == '0) begin
                                key_exh <= 1'b1;
                            end else begin
                                bit_idx <= bit_idx - 1'b1;
                            end
                        end
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Core status mirror, registered every cycle independent of state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            status <= '0;
        end else begin
            status <= becStatus;
        end
    end

endmodule

// File: tb/tb_lovers_bec_sequencer.sv
// Self-checking bench for lovers_bec_sequencer: operand load scoreboard,
// table-driven key streaming, abort, watchdog and async reset sequences.
module tb_lovers_bec_sequencer;

    localparam int DW    = 163;
    localparam int NOPER = 6;
    localparam int KB    = 163;
    localparam int TMO   = 1000;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [KB-1:0] key_in;
    logic          op_req;
    logic [2:0]    op_idx;
    logic          op_valid;
    logic [DW-1:0] op_data;
    logic          enable;
    logic          load_data;
    logic [2:0]    load_status;
    logic [DW-1:0] data_out;
    logic          trigLoad;
    logic          ki;
    logic          next_key;
    logic [3:0]    becStatus;
    logic [DW-1:0] data_in;
    logic          done;
    logic          busy;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          timeout_err;
    logic [3:0]    status;

    lovers_bec_sequencer #(
        .DW(DW), .NUM_OPER(NOPER), .KEY_BITS(KB), .TIMEOUT(TMO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
        .key_in(key_in), .op_req(op_req), .op_idx(op_idx),
        .op_valid(op_valid), .op_data(op_data), .enable(enable),
        .load_data(load_data), .load_status(load_status),
        .data_out(data_out), .trigLoad(trigLoad), .ki(ki),
        .next_key(next_key), .becStatus(becStatus), .data_in(data_in),
        .done(done), .busy(busy), .result(result),
        .result_valid(result_valid), .timeout_err(timeout_err),
        .status(status)
    );

    typedef struct packed {
        logic [2:0]    slot;
        logic [DW-1:0] d;
    } ld_t;

    typedef struct {
        int   pulses;
        logic exp_ki;
    } kvec_t;

    ld_t           exp_q[$];
    logic [DW-1:0] res_q[$];
    kvec_t         kv[6];
    int            n_tests = 0;
    int            n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // Every load strobe must match the operand the host handed over for that slot.
    always @(posedge clk) begin
        #1;
        if (load_data) begin
            if (exp_q.size() == 0) begin
                check("ld_unexpected", load_data, 0);
            end else begin
                ld_t e;
                e = exp_q.pop_front();
                check("ld_slot", load_status, e.slot);
                check("ld_data", data_out, e.d);
            end
        end
    end

    task automatic start_op(input logic [KB-1:0] k);
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("start_op_req", op_req, 1);
        check("start_busy", busy, 1);
        check("start_rv_clr", result_valid, 0);
        check("start_to_clr", timeout_err, 0);
    endtask

    // Host model: odd slots answer op_req 3 cycles late; bp_slot holds trigLoad low for 10 cycles.
    task automatic do_loads(input int bp_slot);
        for (int s = 0; s < NOPER; s++) begin
            int            t;
            logic [DW-1:0] v;
            t = 0;
            while (!op_req && t < 50) begin
                tick();
                t++;
            end
            check("op_req_seen", op_req, 1);
            check("op_idx", op_idx, s);
            if (!op_req) return;
            repeat ((s % 2) ? 3 : 0) tick();
            check("op_req_hold", op_req, 1);
            v        = rnd();
            trigLoad = (s == bp_slot) ? 1'b0 : 1'b1;
            op_data  = v;
            op_valid = 1'b1;
            exp_q.push_back({3'(s), v});
            tick();
            op_valid = 1'b0;
            check("op_req_drop", op_req, 0);
            check("ld_status_cap", load_status, s);
            if (s == bp_slot) begin
                repeat (10) begin
                    tick();
                    check("bp_noload", load_data, 0);
                    check("bp_dout", data_out, v);
                    check("bp_status", load_status, s);
                end
                trigLoad = 1'b1;
            end
            tick();
            check("load_lat", load_data, 1);
        end
    endtask

    task automatic pulses(input int n);
        if (n > 0) begin
            next_key = 1'b1;
            repeat (n) tick();
            next_key = 1'b0;
        end
    endtask

    task automatic finish_op(input logic [DW-1:0] d);
        logic [DW-1:0] e;
        data_in = d;
        done    = 1'b1;
        res_q.push_back(d);
        tick();
        done = 1'b0;
        check("fin_rv", result_valid, 1);
        check("fin_busy", busy, 0);
        check("fin_enable", enable, 0);
        if (res_q.size() != 0) begin
            e = res_q.pop_front();
            check("fin_result", result, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [KB-1:0] k1;
        logic [KB-1:0] k2;
        logic [KB-1:0] k3;
        logic [167:0]  pat;
        logic [DW-1:0] last_res;
        int            cnt;
        int            done_p;

        rst = 1'b1; start = 1'b0; abort = 1'b0; key_in = '0;
        op_valid = 1'b0; op_data = '0; trigLoad = 1'b1; next_key = 1'b0;
        becStatus = '0; data_in = '0; done = 1'b0;

        kv[0] = '{0, 1'b1};
        kv[1] = '{1, 1'b0};
        kv[2] = '{80, 1'b0};
        kv[3] = '{162, 1'b1};
        kv[4] = '{163, 1'b0};
        kv[5] = '{165, 1'b0};

        #3;
        check("rst_op_req", op_req, 0);
        check("rst_enable", enable, 0);
        check("rst_busy", busy, 0);
        check("rst_rv", result_valid, 0);
        check("rst_result", result, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        becStatus = 4'hA;
        tick();
        check("status_mirror", status, 4'hA);

        // Normal run with backpressure on slot 2 and table-driven key streaming.
        k1 = '0;
        k1[KB-1] = 1'b1;
        k1[0] = 1'b1;
        start_op(k1);
        do_loads(2);
        tick();
        check("run_enable", enable, 1);
        done_p = 0;
        for (int i = 0; i < 6; i++) begin
            pulses(kv[i].pulses - done_p);
            done_p = kv[i].pulses;
            check("ki_tab", ki, kv[i].exp_ki);
            check("ki_model", ki, (done_p < KB) ? k1[KB-1-done_p] : 1'b0);
        end
        check("run_enable_hold", enable, 1);
        pat = {21{8'h5A}};
        finish_op(pat[DW-1:0]);
        tick();
        check("idle_rv_hold", result_valid, 1);

        // Abort mid-run at bit 80, then a clean restart.
        k2 = rnd();
        start_op(k2);
        do_loads(-1);
        tick();
        pulses(82);
        check("abort_ki80", ki, k2[80]);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_enable", enable, 0);
        check("abort_busy", busy, 0);
        check("abort_rv", result_valid, 0);
        k3 = rnd();
        k3[KB-1] = ~k2[80];
        start_op(k3);
        do_loads(-1);
        tick();
        check("restart_ki_top", ki, k3[KB-1]);
        pulses(5);
        check("restart_ki5", ki, k3[KB-6]);
        last_res = rnd();
        finish_op(last_res);
        tick();

        // Watchdog with an ignored start while busy.
        start_op(k1);
        do_loads(-1);
        tick();
        cnt = 0;
        while (!timeout_err && cnt < TMO + 100) begin
            start = (cnt == 5);
            tick();
            cnt++;
            if (cnt == 6) begin
                check("busy_start_busy", busy, 1);
                check("busy_start_req", op_req, 0);
                check("busy_start_en", enable, 1);
            end
        end
        start = 1'b0;
        check("wd_cycles", cnt, TMO);
        check("wd_err", timeout_err, 1);
        check("wd_enable", enable, 0);
        check("wd_busy", busy, 0);
        check("wd_rv", result_valid, 0);

        // done outside RUN must not disturb the captured result.
        data_in = rnd();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("idle_done_rv", result_valid, 0);
        check("idle_done_res", result, last_res);

        // Async reset while the load strobe is high.
        start_op(k2);
        op_data  = rnd();
        op_valid = 1'b1;
        exp_q.push_back({3'd0, op_data});
        tick();
        op_valid = 1'b0;
        tick();
        check("strobe_seen", load_data, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_load", load_data, 0);
        check("arst_busy", busy, 0);
        check("arst_dout", data_out, 0);
        check("arst_result", result, 0);
        check("arst_status", status, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        start_op(k1);
        check("post_rst_idx", op_idx, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("post_rst_abort", busy, 0);
        check("ld_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lovers_bec_sequencer.md
Name: lovers_bec_sequencer

Overview:
Host-facing sequencer for the 163-bit binary-Edwards-curve scalar-multiplication core. On a start command it fetches operands from the host one slot at a time and loads each into the core over the load_status/load_data/trigLoad handshake. It then enables the core and feeds it scalar key bits MSB-first on every next_key request, and captures the result on done. It sits between the control unit and the BEC core and replaces ad-hoc sequencing in the controller.

Parameters:
DW, 163, field/operand width in bits
NUM_OPER, 6, operand slots loaded per operation (slot index on load_status, must be <= 8)
KEY_BITS, 163, scalar length in bits consumed per operation
TIMEOUT, 2^20, cycles allowed in RUN before done; 0 disables the watchdog

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous active-high reset
start  in  1  one-cycle start pulse; ignored unless idle
abort  in  1  synchronous abort; returns to IDLE
key_in  in  KEY_BITS  scalar, latched on accepted start
op_req  out  1  sequencer requests operand op_idx
op_idx  out  3  requested slot
op_valid  in  1  host presents op_data for op_idx
op_data  in  DW  operand value
enable  out  1  core enable
load_data  out  1  one-cycle load strobe to core
load_status  out  3  slot being loaded
data_out  out  DW  operand bus to core
trigLoad  in  1  core ready to accept the current slot
ki  out  1  current key bit
next_key  in  1  core consumed ki; advance
becStatus  in  4  core status, mirrored
data_in  in  DW  core result bus
done  in  1  core finished (pulse)
busy  out  1  operation in progress
result  out  DW  captured result
result_valid  out  1  result holds a completed operation
timeout_err  out  1  watchdog fired
status  out  4  registered copy of becStatus

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; key_reg, result, slot counter and bit index cleared.
- States: IDLE, FETCH, LOAD, STROBE, RUN, FINISH.
- IDLE: on start, latch key_in and set bit_idx=KEY_BITS-1, slot=0, busy=1, clear result_valid and timeout_err, then go to FETCH. start is ignored in any other state.
- FETCH: op_req=1 and op_idx=slot. On op_valid, register op_data into data_out, drop op_req the next cycle, go to LOAD.
- LOAD: load_status=slot; wait for trigLoad=1, then go to STROBE.
- STROBE: load_data=1 for exactly one cycle. If slot==NUM_OPER-1, go to RUN. Otherwise slot+1 and go to FETCH.
- data_out and load_status stay stable from FETCH capture through STROBE.
- RUN: enable=1 and ki=key_reg[bit_idx] (combinational from registers).
  - On next_key, bit_idx decrements and ki shows the new bit the next cycle.
  - After bit 0 has been consumed, bit_idx saturates and ki=0.
  - Watchdog counts cycles in RUN. If it reaches TIMEOUT without done: timeout_err=1, enable=0, go to IDLE (busy=0, result_valid stays 0).
- done in RUN: result<=data_in in the same edge, enable=0, go to FINISH.
  - done coinciding with next_key: capture wins; the bit advance is irrelevant.
  - done seen outside RUN is ignored.
- FINISH: result_valid=1 and busy=0 the next cycle, then go to IDLE. result holds until the next accepted start.
- abort in any non-IDLE state takes priority over all other transitions:
  - enable, load_data and op_req drop on the next edge; state goes to IDLE.
  - result_valid=0; timeout_err unchanged.
- Latency minima:
  - start to first op_req: 1 cycle.
  - op_valid to load_data, with trigLoad already high: 2 cycles.
  - done to result_valid: 1 cycle.
- status<=becStatus every cycle regardless of state.

Test Plan:
- Normal run: NUM_OPER=6, host answers op_req after 0 and 3 cycles, trigLoad tied 1 -> six load_data pulses with load_status 0..5, each data_out equal to the supplied operand. Then enable=1, and a core model asserting done after 163 next_key pulses with data_in=0x5A5A… -> result matches, result_valid=1, busy=0.
- Key streaming: key_in=163'h4000…0001 -> ki=1 before the first next_key, 0 for the middle bits, 1 at bit 0, and 0 after 163 pulses even with extra next_key pulses.
- trigLoad backpressure: hold trigLoad=0 for 10 cycles in LOAD slot 2 -> no load_data; data_out and load_status stable; load_data pulses exactly once after trigLoad rises.
- Abort mid-RUN at bit 80 -> enable=0 next cycle, busy=0, result_valid=0. A new start then completes normally with bit_idx restarted at 162.
- Watchdog with TIMEOUT=1000 and no done -> timeout_err=1 exactly 1000 cycles after entering RUN, enable=0. A start while busy is ignored.
- Async reset asserted during STROBE -> all outputs 0 immediately, without waiting for a clock edge. After release the block accepts start.
